// File: rtl/vga_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_gen
// Purpose  : Wall + bouncing-square pixel generator with one-tick sync delay.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_gen #(
    parameter int          H_DISPLAY  = 640,
    parameter int          V_DISPLAY  = 480,
    parameter int          SQ_SIZE    = 16,
    parameter int          SPEED      = 2,
    parameter int          X0         = 100,
    parameter int          Y0         = 50,
    parameter logic [11:0] SQ_COLOR   = 12'hF00,
    parameter logic [11:0] WALL_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h00F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_tick
);

    localparam logic [10:0] c_H_DISP = 11'(H_DISPLAY);
    localparam logic [10:0] c_V_DISP = 11'(V_DISPLAY);
    localparam logic [10:0] c_SQ     = 11'(SQ_SIZE);
    localparam logic [10:0] c_SPD    = 11'(SPEED);
    localparam logic [9:0]  c_SPD10  = 10'(SPEED);
    localparam logic [9:0]  c_X_MAX  = 10'(H_DISPLAY - SQ_SIZE);
    localparam logic [9:0]  c_Y_MAX  = 10'(V_DISPLAY - SQ_SIZE);
    localparam logic [9:0]  c_H_LAST = 10'(H_DISPLAY - 1);
    localparam logic [9:0]  c_V_LAST = 10'(V_DISPLAY - 1);
    localparam logic [9:0]  c_V_TICK = 10'(V_DISPLAY);
    localparam logic [9:0]  c_X0     = 10'(X0);
    localparam logic [9:0]  c_Y0     = 10'(Y0);
    localparam logic        c_DIR_POS = 1'b0;  // right / down
    localparam logic        c_DIR_NEG = 1'b1;  // left / up

    logic [9:0]  r_sq_x, r_sq_y;
    logic        r_dir_x, r_dir_y;
    logic [9:0]  w_nx, w_ny;
    logic        w_ndx, w_ndy;
    logic        w_wall, w_in_sq;
    logic [10:0] w_px, w_py, w_sx, w_sy;
    logic [11:0] w_color;

    // Widen to 11 bits so sq + SQ_SIZE cannot wrap near the right/bottom edge
    assign w_px = {1'b0, pixel_x};
    assign w_py = {1'b0, pixel_y};
    assign w_sx = {1'b0, r_sq_x};
    assign w_sy = {1'b0, r_sq_y};

    assign w_wall  = (pixel_x == 10'd0) || (pixel_x == c_H_LAST) ||
                     (pixel_y == 10'd0) || (pixel_y == c_V_LAST);
    assign w_in_sq = (w_px >= w_sx) && (w_px < w_sx + c_SQ) &&
                     (w_py >= w_sy) && (w_py < w_sy + c_SQ);

    always_comb begin
        w_color = BG_COLOR;
        if (!video_on)
            w_color = 12'h000;
        else if (w_wall)
            w_color = WALL_COLOR;
        else if (w_in_sq)
            w_color = SQ_COLOR;
    end

    always_comb begin
        w_nx  = r_sq_x;
        w_ndx = r_dir_x;
        w_ny  = r_sq_y;
        w_ndy = r_dir_y;
        if (r_dir_x == c_DIR_POS) begin
            if (w_sx + c_SQ + c_SPD > c_H_DISP) begin
                w_nx  = c_X_MAX;
                w_ndx = c_DIR_NEG;
            end else begin
                w_nx = r_sq_x + c_SPD10;
            end
        end else if (w_sx < c_SPD) begin
            w_nx  = 10'd0;
            w_ndx = c_DIR_POS;
        end else begin
            w_nx = r_sq_x - c_SPD10;
        end
        if (r_dir_y == c_DIR_POS) begin
            if (w_sy + c_SQ + c_SPD > c_V_DISP) begin
                w_ny  = c_Y_MAX;
                w_ndy = c_DIR_NEG;
            end else begin
                w_ny = r_sq_y + c_SPD10;
            end
        end else if (w_sy < c_SPD) begin
            w_ny  = 10'd0;
            w_ndy = c_DIR_POS;
        end else begin
            w_ny = r_sq_y - c_SPD10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb        <= 12'h000;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= p_tick && (pixel_x == 10'd0) && (pixel_y == c_V_TICK);
            if (p_tick) begin
                rgb       <= w_color;
                hsync_out <= hsync_in;
                vsync_out <= vsync_in;
            end
        end
    end

    // Motion advances in the clock where the registered frame_tick is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sq_x  <= c_X0;
            r_sq_y  <= c_Y0;
            r_dir_x <= c_DIR_POS;
            r_dir_y <= c_DIR_POS;
        end else if (frame_tick && !pause) begin
            r_sq_x  <= w_nx;
            r_sq_y  <= w_ny;
            r_dir_x <= w_ndx;
            r_dir_y <= w_ndy;
        end
    end

endmodule
`default_nettype wire
